// File: rtl/score_pkg.sv
// Shared widths, FSM state type and seven-segment codes for the score display path.
package score_pkg;

    localparam int SCORE_W = 8;
    localparam int BCD_W   = 12;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } state_t;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Double-dabble correction applied to one BCD nibble before each shift
    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// One BCD digit to active-low DE2 seven-segment pattern, with forced blanking.
module seg7_decoder
    import score_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/score_display_driver.sv
// Converts the selected 8-bit score to three decimal digits with a sequential
// double-dabble engine and drives three seven-segment displays; tracks the session best.
module score_display_driver
    import score_pkg::*;
#(
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [SCORE_W-1:0] current_highscore,
    input  logic               game_over,
    input  logic               show_best,
    output logic [SCORE_W-1:0] best_score,
    output logic               busy,
    output logic [6:0]         HEX2,
    output logic [6:0]         HEX1,
    output logic [6:0]         HEX0
);

    state_t                     state, state_next;
    logic [SCORE_W-1:0]         src, last_src;
    logic [BCD_W+SCORE_W-1:0]   sr;
    logic [BCD_W-1:0]           bcd_adj;
    logic [2:0]                 cnt;
    logic [3:0]                 d2, d1, d0;
    logic                       blank2, blank1;

    always_comb begin
        src = show_best ? best_score : current_highscore;
    end

    always_comb begin
        bcd_adj = {add3(sr[19:16]), add3(sr[15:12]), add3(sr[11:8])};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (src != last_src) state_next = SHIFT;
            SHIFT:   if (cnt == 3'd7) state_next = LATCH;
            LATCH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Source changes while busy are not queued; the IDLE compare picks up the latest value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_src <= '0;
            sr       <= '0;
            cnt      <= '0;
            d2       <= '0;
            d1       <= '0;
            d0       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (src != last_src) begin
                        last_src <= src;
                        sr       <= {{BCD_W{1'b0}}, src};
                        cnt      <= '0;
                    end
                end
                SHIFT: begin
                    sr  <= {bcd_adj[BCD_W-2:0], sr[SCORE_W-1:0], 1'b0};
                    cnt <= cnt + 3'd1;
                end
                LATCH: begin
                    d2 <= sr[19:16];
                    d1 <= sr[15:12];
                    d0 <= sr[11:8];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            best_score <= '0;
        end else if (game_over && (current_highscore > best_score)) begin
            best_score <= current_highscore;
        end
    end

    always_comb begin
        busy   = (state != IDLE);
        blank2 = BLANK_LEADING && (d2 == 4'd0);
        blank1 = BLANK_LEADING && (d2 == 4'd0) && (d1 == 4'd0);
    end

    seg7_decoder u_dec2 (.digit(d2), .blank(blank2), .seg(HEX2));
    seg7_decoder u_dec1 (.digit(d1), .blank(blank1), .seg(HEX1));
    seg7_decoder u_dec0 (.digit(d0), .blank(1'b0),   .seg(HEX0));

endmodule
